// File: rtl/io_bus_arbiter.sv
// Round-robin owner arbiter for a shared inout bus.
// At most one output-enable is active, and owners are separated by TURNAROUND idle cycles.
module io_bus_arbiter #(
  parameter int N          = 2,
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1,
  localparam int OW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic          CLK,
  input  logic          ASYNCRESETN,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [N-1:0]  oe,
  output logic [OW-1:0] owner,
  output logic          busy,
  output logic          preempt
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] TURN = 2'd2;

  logic [1:0]    state;
  logic [OW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] turn_cnt;

  logic [OW-1:0] win;
  logic          any_req, arb_go, own_req, others_req, hold_hit, leave;

  assign oe = grant;

  // Search order starts at the pointer and wraps, so the last owner ranks lowest.
  always_comb begin
    logic found;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        win   = OW'((int'(ptr) + i) % N);
      end
    end
  end

  assign any_req    = |req;
  assign arb_go     = any_req && ((state == IDLE) || (state == TURN && turn_cnt == '0));
  assign own_req    = req[owner];
  assign others_req = |(req & ~grant);
  assign hold_hit   = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD)) && others_req;
  assign leave      = (state == OWN) && (!own_req || hold_hit);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      preempt <= 1'b0;
      if (arb_go) begin
        state    <= OWN;
        grant    <= {{(N-1){1'b0}}, 1'b1} << win;
        owner    <= win;
        busy     <= 1'b1;
        hold_cnt <= HW'(1);
      end else begin
        case (state)
          OWN: begin
            if (leave) begin
              state    <= TURN;
              grant    <= '0;
              preempt  <= own_req;
              turn_cnt <= TW'(TURNAROUND - 1);
              ptr      <= (owner == OW'(N - 1)) ? '0 : owner + 1'b1;
            end else if (MAX_HOLD != 0 && hold_cnt != HW'(MAX_HOLD)) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          TURN: begin
            if (turn_cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              turn_cnt <= turn_cnt - 1'b1;
            end
          end
          IDLE: ;
          default: begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized and directed bench for io_bus_arbiter.
// A cycle-stepped ownership model predicts every output on every cycle.
module tb_io_bus_arbiter;
  localparam int N  = 4;
  localparam int MH = 5;
  localparam int TA = 2;
  localparam int OW = 2;

  logic          CLK = 1'b0;
  logic          ASYNCRESETN;
  logic [N-1:0]  req;
  logic [N-1:0]  grant, oe;
  logic [OW-1:0] owner;
  logic          busy, preempt;

  int n_chk  = 0;
  int n_fail = 0;

  // cur = owning requester or -1; gap = idle cycles still to run before arbitrating
  int   cur, held, gap, nxt, last;
  logic m_pre;

  io_bus_arbiter #(.N(N), .MAX_HOLD(MH), .TURNAROUND(TA)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .req(req), .grant(grant), .oe(oe),
    .owner(owner), .busy(busy), .preempt(preempt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur = -1; held = 0; gap = 0; nxt = 0; last = 0; m_pre = 1'b0;
  endtask

  task automatic model_arb(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (cur < 0 && r[(nxt + i) % N]) begin
        cur  = (nxt + i) % N;
        held = 1;
        last = cur;
      end
    end
  endtask

  task automatic model_step(input logic [N-1:0] r);
    logic [N-1:0] others;
    logic         go;
    m_pre = 1'b0;
    if (cur >= 0) begin
      others = r;
      others[cur] = 1'b0;
      go = 1'b0;
      if (!r[cur]) go = 1'b1;
      else if (MH != 0 && held >= MH && others != '0) begin
        go = 1'b1;
        m_pre = 1'b1;
      end else held++;
      if (go) begin
        nxt = (cur + 1) % N;
        cur = -1;
        gap = TA;
      end
    end else if (gap > 0) begin
      gap--;
      if (gap == 0) model_arb(r);
    end else begin
      model_arb(r);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (cur >= 0) eg[cur] = 1'b1;
    chk({tag, ".grant"},   32'(grant),   32'(eg));
    chk({tag, ".oe"},      32'(oe),      32'(eg));
    chk({tag, ".owner"},   32'(owner),   32'(last));
    chk({tag, ".busy"},    32'(busy),    32'(cur >= 0 || gap > 0));
    chk({tag, ".preempt"}, 32'(preempt), 32'(m_pre));
    chk({tag, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic step_chk(input string tag);
    @(posedge CLK);
    model_step(req);
    #1;
    check_all(tag);
  endtask

  task automatic tick(input string tag, input logic [N-1:0] r, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      req = r;
      step_chk(tag);
    end
  endtask

  initial begin
    logic [N-1:0] r;
    ASYNCRESETN = 1'b0;
    req = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge CLK);
    ASYNCRESETN = 1'b1;

    tick("single",   4'b0001, 3);
    tick("release",  4'b0000, 4);
    tick("pair",     4'b0011, 14);
    tick("idle1",    4'b0000, 3);
    tick("solo",     4'b0001, 20);
    tick("idle2",    4'b0000, 3);
    tick("all",      4'b1111, 40);
    tick("idle3",    4'b0000, 3);
    tick("pulse",    4'b0100, 1);
    tick("pulse2",   4'b1000, 1);
    tick("idle4",    4'b0000, 6);

    // async reset between edges while someone owns the bus
    tick("preown",   4'b0001, 3);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    step_chk("post_rst");

    r = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      tick("rand", r, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
